// File: rtl/bpsk_mod.sv
// bpsk_mod: BPSK modulator with a 16-bit phase-accumulator carrier.
// Each serial input bit is held for SYM_LEN cycles and sets the sign of a
// 64-point sine carrier. The sample path is a three-stage pipeline
// (index capture, sine lookup, sign apply), so the output lags by 3 cycles.
//
// Build option: define BPSK_DIFF_ENC_EN to enable differential encoding
// (DPSK). In that build the applied bit is bit_in XOR the previous applied
// bit. Without the macro the applied bit is bit_in and no differential
// state register exists.

module bpsk_mod #(
    parameter int          SYM_LEN   = 64,
    parameter logic [15:0] FREQ_WORD = 16'h0400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              bit_in,
    output logic              sym_tick,
    output logic              data_bit,
    output logic signed [7:0] mod_out,
    output logic              mod_valid
);

    // Counter width covers 0..SYM_LEN-1; SYM_LEN >= 2 keeps this at least 1 bit.
    localparam int                CNT_W   = (SYM_LEN > 2) ? $clog2(SYM_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SYM_LEN - 1);

    // ------------------------------------------------------------------
    // Symbol timing and bit selection
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] sym_cnt;
    logic [15:0]      phase;
    logic             cur_bit;
    logic             at_sym_start;
    logic             sym_start;
    logic             new_bit;
    logic             bit_use;

    assign at_sym_start = (sym_cnt == '0);
    assign sym_start    = en && at_sym_start;

`ifdef BPSK_DIFF_ENC_EN
    logic diff_state;

    // Previous applied bit; only reset clears it, so it survives en drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_state <= 1'b0;
        end else if (sym_start) begin
            diff_state <= new_bit;
        end
    end

    assign new_bit = bit_in ^ diff_state;
`else
    assign new_bit = bit_in;
`endif

    // The bit fed to the carrier: the fresh sample on the symbol's first
    // cycle, the held bit afterwards.
    assign bit_use = at_sym_start ? new_bit : cur_bit;

    // Symbol counter, held bit and symbol-start pulse.
    // NOTE: every clocked block uses non-blocking (<=) assignments so that all
    // registers update together from pre-edge values, with no ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sym_cnt  <= '0;
            sym_tick <= 1'b0;
            cur_bit  <= 1'b0;
        end else if (!en) begin
            // Idle abandons any partial symbol; the next enable starts fresh.
            sym_cnt  <= '0;
            sym_tick <= 1'b0;
        end else begin
            sym_tick <= at_sym_start;
            if (at_sym_start) begin
                cur_bit <= new_bit;
            end
            if (sym_cnt == CNT_MAX) begin
                sym_cnt <= '0;
            end else begin
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

    assign data_bit = cur_bit;

    // Carrier phase accumulator; wraps modulo 2^16 and runs straight across
    // symbol boundaries so the carrier stays phase-continuous.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            phase <= '0;
        end else begin
            phase <= phase + FREQ_WORD;
        end
    end

    // ------------------------------------------------------------------
    // Stage A: table index, bit in use and sample valid
    // ------------------------------------------------------------------
    logic [5:0] idx_a;
    logic       bit_a;
    logic       valid_a;

    // Capture the top six phase bits alongside the bit that modulates them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_a   <= '0;
            bit_a   <= 1'b0;
            valid_a <= 1'b0;
        end else begin
            idx_a   <= phase[15:10];
            bit_a   <= bit_use;
            valid_a <= en;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: quarter-wave sine lookup
    // ------------------------------------------------------------------

    // Magnitude of sin over one quarter wave, 17 points (0..16) scaled to 127.
    // NOTE: this table is a constant ROM decoded from a case statement, not a
    // storage array, so it has no contents to reset or initialise.
    function automatic logic [6:0] quarter_mag(input logic [4:0] addr);
        logic [6:0] m;
        m = '0;
        case (addr)
            5'd0:    m = 7'd0;
            5'd1:    m = 7'd12;
            5'd2:    m = 7'd25;
            5'd3:    m = 7'd37;
            5'd4:    m = 7'd49;
            5'd5:    m = 7'd60;
            5'd6:    m = 7'd71;
            5'd7:    m = 7'd81;
            5'd8:    m = 7'd90;
            5'd9:    m = 7'd98;
            5'd10:   m = 7'd106;
            5'd11:   m = 7'd112;
            5'd12:   m = 7'd117;
            5'd13:   m = 7'd122;
            5'd14:   m = 7'd125;
            5'd15:   m = 7'd126;
            5'd16:   m = 7'd127;
            default: m = 7'd0;
        endcase
        return m;
    endfunction

    logic [4:0]        lut_addr;
    logic [6:0]        lut_mag;
    logic signed [7:0] sine_val;

    // Fold the 64-point cycle onto the quarter table: idx[4] mirrors the
    // address (falling half of each lobe), idx[5] negates (second half-cycle).
    // NOTE: every signal driven here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        lut_addr = {1'b0, idx_a[3:0]};
        lut_mag  = '0;
        sine_val = '0;
        if (idx_a[4]) begin
            lut_addr = 5'd16 - {1'b0, idx_a[3:0]};
        end
        lut_mag  = quarter_mag(lut_addr);
        sine_val = idx_a[5] ? -$signed({1'b0, lut_mag}) : $signed({1'b0, lut_mag});
    end

    logic signed [7:0] sine_b;
    logic              bit_b;
    logic              valid_b;

    // Register the looked-up carrier sample with its bit and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sine_b  <= '0;
            bit_b   <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            sine_b  <= sine_val;
            bit_b   <= bit_a;
            valid_b <= valid_a;
        end
    end

    // ------------------------------------------------------------------
    // Stage C: BPSK sign and output gating
    // ------------------------------------------------------------------

    // Bit 1 passes the carrier, bit 0 inverts it; invalid slots output 0.
    // The carrier never reaches -128, so negation cannot overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mod_out   <= '0;
            mod_valid <= 1'b0;
        end else begin
            mod_valid <= valid_b;
            if (!valid_b) begin
                mod_out <= '0;
            end else if (bit_b) begin
                mod_out <= sine_b;
            end else begin
                mod_out <= -sine_b;
            end
        end
    end

endmodule
